multiword_add_sequencer: RTL

//   Sequences one N-bit carry_select_adder over multi-word operands, LS word first.

---
 rtl/multiword_add_sequencer.sv | 100 ++++++++++
 1 files changed

// File: rtl/multiword_add_sequencer.sv
// multiword_add_sequencer: streams multi-word add/sub through one carry-select adder, LS word first
module multiword_add_sequencer #(
  parameter int N     = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [CNT_W-1:0] cmd_words,
  input  logic             cmd_sub,
  input  logic             cmd_cin,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_a,
  input  logic [N-1:0]     in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_sum,
  output logic             out_last,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             busy
);
  localparam int L = N / 2;
  localparam int U = N - L;
  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;
  logic sub_q, sub_d, carry_q, carry_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic valid_q, valid_d, last_q, last_d, cout_q, cout_d, ovf_q, ovf_d;
  logic [N-1:0] sum_q, sum_d, b_x, sum;
  logic [L:0] lo;
  logic [U:0] hi0, hi1, hi;
  logic cout, ovf, cmd_hs, in_hs, last_beat;
  assign b_x = in_b ^ {N{sub_q}};
  assign lo = {1'b0, in_a[L-1:0]} + {1'b0, b_x[L-1:0]} + {{L{1'b0}}, carry_q};
  assign hi0 = {1'b0, in_a[N-1:L]} + {1'b0, b_x[N-1:L]};
  assign hi1 = {1'b0, in_a[N-1:L]} + {1'b0, b_x[N-1:L]} + {{U{1'b0}}, 1'b1};
  assign hi = lo[L] ? hi1 : hi0;
  assign sum = {hi[U-1:0], lo[L-1:0]};
  assign cout = hi[U];
  assign ovf = (in_a[N-1] == b_x[N-1]) & (sum[N-1] != in_a[N-1]);
  assign cmd_ready = state_q == IDLE;
  assign busy = state_q == RUN;
  assign in_ready = busy & (~valid_q | out_ready);
  assign cmd_hs = cmd_valid & cmd_ready;
  assign in_hs = in_valid & in_ready;
  assign last_beat = rem_q == CNT_W'(1);
  assign out_valid = valid_q;
  assign out_sum = sum_q;
  assign out_last = last_q;
  assign out_cout = cout_q;
  assign out_ovf = ovf_q;
  always_comb begin
    state_d = state_q;
    sub_d = sub_q;
    carry_d = carry_q;
    rem_d = rem_q;
    valid_d = in_hs | (valid_q & ~out_ready);
    sum_d = in_hs ? sum : sum_q;
    last_d = in_hs ? last_beat : last_q;
    cout_d = in_hs ? last_beat & cout : cout_q;
    ovf_d = in_hs ? last_beat & ovf : ovf_q;
    if (cmd_hs && cmd_words != '0) begin
      state_d = RUN;
      sub_d = cmd_sub;
      carry_d = cmd_sub | cmd_cin;
      rem_d = cmd_words;
    end
    if (in_hs) begin
      carry_d = cout;
      rem_d = rem_q - CNT_W'(1);
      state_d = last_beat ? IDLE : RUN;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sub_q <= 1'b0;
      carry_q <= 1'b0;
      rem_q <= '0;
      valid_q <= 1'b0;
      sum_q <= '0;
      last_q <= 1'b0;
      cout_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sub_q <= sub_d;
      carry_q <= carry_d;
      rem_q <= rem_d;
      valid_q <= valid_d;
      sum_q <= sum_d;
      last_q <= last_d;
      cout_q <= cout_d;
      ovf_q <= ovf_d;
    end
  end
endmodule
